// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
`ifndef AW
`define AW 9
`endif
`ifndef DW
`define DW 8
`endif

package apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

    typedef struct packed {
        logic [`AW-1:0] addr;
        logic [`DW-1:0] wdata;
        logic           rw;
    } apb_req_t;

    // Request address bit that picks slave 2 over slave 1.
    localparam int unsigned SelBit = `AW - 1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; flags the cycle on which the TIMEOUT-th wait would elapse.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic reached
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign reached = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns a level-valid request into SETUP/ACCESS cycles on one of two slaves.
`ifndef AW
`define AW 9
`endif
`ifndef DW
`define DW 8
`endif

module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned AW      = `AW,
    parameter int unsigned DW      = `DW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          transfer,
    input  logic          READ_WRITE,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [AW-1:0] apb_read_paddr,
    input  logic [DW-1:0] apb_write_data,
    output logic [DW-1:0] apb_read_data_out,
    output logic          done,
    output logic          err,
    output logic          PSEL1,
    output logic          PSEL2,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-2:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA1,
    input  logic [DW-1:0] PRDATA2,
    input  logic          PREADY1,
    input  logic          PREADY2,
    input  logic          PSLVERR
);
    apb_state_e    state_q, state_d;
    apb_req_t      new_req, req_q, req_d, bus_q, bus_d;
    logic          psel1_q, psel1_d, psel2_q, psel2_d;
    logic          penable_q, penable_d, pwrite_q, pwrite_d;
    logic          done_q, done_d, err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d, sel_rdata;
    logic          sel_ready, in_access, timed_out, complete, waiting, issue_setup;

    always_comb begin
        new_req.addr  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
        new_req.wdata = apb_write_data;
        new_req.rw    = READ_WRITE;
    end

    assign sel_ready = bus_q.addr[SelBit] ? PREADY2 : PREADY1;
    assign sel_rdata = bus_q.addr[SelBit] ? PRDATA2 : PRDATA1;

    // Outputs are registered, so the bus shows ACCESS one cycle after the FSM enters it;
    // slave responses only count once PENABLE is actually on the bus.
    assign in_access   = (state_q == StAccess) && penable_q;
    assign complete    = in_access && (sel_ready || timed_out);
    assign waiting     = in_access && !sel_ready && !timed_out;
    assign issue_setup = (state_q == StSetup) || (complete && transfer);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clr     (!waiting),
        .en      (waiting),
        .reached (timed_out)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= StIdle;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    state_d = StSetup;
                    req_d   = new_req;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                // Back-to-back: the new SETUP goes on the bus at this edge, so ACCESS follows.
                if (complete) begin
                    state_d = transfer ? StAccess : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_d     = bus_q;
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        if (complete) begin
            done_d = 1'b1;
            err_d  = sel_ready ? PSLVERR : 1'b1;
            if (sel_ready && bus_q.rw) begin
                rdata_d = sel_rdata;
            end
        end
        if (issue_setup) begin
            bus_d     = (state_q == StSetup) ? req_q : new_req;
            psel1_d   = !bus_d.addr[SelBit];
            psel2_d   = bus_d.addr[SelBit];
            penable_d = 1'b0;
            pwrite_d  = !bus_d.rw;
        end else if (complete || (state_q == StIdle)) begin
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
        end else if (state_q == StAccess) begin
            penable_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bus_q     <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            bus_q     <= bus_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign PSEL1             = psel1_q;
    assign PSEL2             = psel2_q;
    assign PENABLE           = penable_q;
    assign PWRITE            = pwrite_q;
    assign PADDR             = bus_q.addr[AW-2:0];
    assign PWDATA            = bus_q.wdata;
    assign done              = done_q;
    assign err               = err_q;
    assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed requests, queued expectations, done-driven monitor.
`ifndef AW
`define AW 9
`endif
`ifndef DW
`define DW 8
`endif

module tb_apb_master_bridge;
    localparam int unsigned AW = `AW;
    localparam int unsigned DW = `DW;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          transfer, READ_WRITE;
    logic [AW-1:0] apb_write_paddr, apb_read_paddr;
    logic [DW-1:0] apb_write_data, apb_read_data_out;
    logic          done, err, PSEL1, PSEL2, PENABLE, PWRITE;
    logic [AW-2:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA1, PRDATA2;
    logic          PREADY1, PREADY2, PSLVERR;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            wait_n = 0;
    int            pen;
    logic          never_ready = 1'b0;
    logic          slverr_v = 1'b0;
    logic [DW-1:0] rdata_v = '0;
    logic          ready_now;

    apb_master_bridge #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (16)
    ) dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_data_out (apb_read_data_out),
        .done              (done),
        .err               (err),
        .PSEL1             (PSEL1),
        .PSEL2             (PSEL2),
        .PENABLE           (PENABLE),
        .PWRITE            (PWRITE),
        .PADDR             (PADDR),
        .PWDATA            (PWDATA),
        .PRDATA1           (PRDATA1),
        .PRDATA2           (PRDATA2),
        .PREADY1           (PREADY1),
        .PREADY2           (PREADY2),
        .PSLVERR           (PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave model: the selected slave inserts wait_n wait states; the idle one shows junk.
    assign ready_now = PENABLE && !never_ready && (acc_cnt >= wait_n);
    always @(posedge PCLK) acc_cnt <= (PENABLE && !ready_now) ? acc_cnt + 1 : 0;
    assign PREADY1 = PSEL1 ? ready_now : 1'b1;
    assign PREADY2 = PSEL2 ? ready_now : 1'b1;
    assign PRDATA1 = PSEL1 ? rdata_v : 8'hEE;
    assign PRDATA2 = PSEL2 ? rdata_v : 8'hEE;
    assign PSLVERR = slverr_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_psel1"}, 32'(PSEL1), 0);
        chk({name, "_psel2"}, 32'(PSEL2), 0);
        chk({name, "_penable"}, 32'(PENABLE), 0);
        chk({name, "_pwrite"}, 32'(PWRITE), 0);
        chk({name, "_paddr"}, 32'(PADDR), 0);
        chk({name, "_pwdata"}, 32'(PWDATA), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_err"}, 32'(err), 0);
        chk({name, "_rdata"}, 32'(apb_read_data_out), 0);
    endtask

    task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        READ_WRITE = rw;
        if (rw) begin
            apb_read_paddr  = addr;
            apb_write_paddr = ~addr;
        end else begin
            apb_write_paddr = addr;
            apb_read_paddr  = ~addr;
        end
        apb_write_data = wd;
        transfer       = 1'b1;
    endtask

    task automatic expect_done(input logic e, input logic [DW-1:0] rd, input int at);
        exp_t x;
        x.err   = e;
        x.rdata = rd;
        x.cyc   = at;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0) && (n < 64)) begin
            @(negedge PCLK);
            n++;
        end
        chk({name, "_drained"}, sb.size(), 0);
        @(negedge PCLK);
    endtask

    task automatic count_penable(input string name, input int required);
        pen = 0;
        for (int i = 0; (i < 40) && !done; i++) begin
            @(negedge PCLK);
            if (PENABLE) pen++;
        end
        chk({name, "_penable_cycles"}, pen, required);
    endtask

    // Monitor: bus invariants every cycle, scoreboard pop on every done pulse.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET) begin
            chk("psel_exclusive", 32'(PSEL1 & PSEL2), 0);
            chk("penable_needs_psel", 32'(PENABLE & ~(PSEL1 | PSEL2)), 0);
            chk("err_without_done", 32'(err & ~done), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("done_err", 32'(err), 32'(e.err));
                    chk("done_rdata", 32'(apb_read_data_out), 32'(e.rdata));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        PRESET = 1'b1;
        transfer = 1'b0;
        READ_WRITE = 1'b0;
        apb_write_paddr = '0;
        apb_read_paddr = '0;
        apb_write_data = '0;
        repeat (2) @(negedge PCLK);
        check_idle("reset");
        PRESET = 1'b0;
        @(negedge PCLK);

        // Zero-wait write to slave 1.
        rdata_v = 8'hA1;
        req(1'b0, 9'h005, 8'h5A);
        expect_done(1'b0, 8'h00, cyc + 4);
        @(negedge PCLK);
        transfer = 1'b0;
        chk("t1_psel_latency", 32'(PSEL1), 0);
        @(negedge PCLK);
        chk("t1_psel1", 32'(PSEL1), 1);
        chk("t1_psel2", 32'(PSEL2), 0);
        chk("t1_pwrite", 32'(PWRITE), 1);
        chk("t1_paddr", 32'(PADDR), 'h05);
        chk("t1_pwdata", 32'(PWDATA), 'h5A);
        chk("t1_setup_penable", 32'(PENABLE), 0);
        @(negedge PCLK);
        chk("t1_access_penable", 32'(PENABLE), 1);
        drain("t1");

        // Read from slave 2 with three wait states.
        rdata_v = 8'hC3;
        wait_n = 3;
        req(1'b1, 9'h10C, 8'hFF);
        expect_done(1'b0, 8'hC3, cyc + 7);
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        chk("t2_psel2", 32'(PSEL2), 1);
        chk("t2_psel1", 32'(PSEL1), 0);
        chk("t2_paddr", 32'(PADDR), 'h0C);
        chk("t2_pwrite", 32'(PWRITE), 0);
        count_penable("t2", 4);
        drain("t2");

        // Back-to-back: write slave 1, then read slave 2, transfer held high.
        wait_n = 0;
        rdata_v = 8'h3C;
        n = cyc;
        req(1'b0, 9'h033, 8'h96);
        expect_done(1'b0, 8'hC3, n + 4);
        expect_done(1'b0, 8'h3C, n + 6);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t3_first_psel1", 32'(PSEL1), 1);
        req(1'b1, 9'h1A5, 8'h00);
        @(negedge PCLK);
        chk("t3_first_penable", 32'(PENABLE), 1);
        chk("t3_first_pwdata", 32'(PWDATA), 'h96);
        @(negedge PCLK);
        transfer = 1'b0;
        chk("t3_second_psel2", 32'(PSEL2), 1);
        chk("t3_second_psel1", 32'(PSEL1), 0);
        chk("t3_second_setup_penable", 32'(PENABLE), 0);
        chk("t3_second_paddr", 32'(PADDR), 'hA5);
        chk("t3_second_pwrite", 32'(PWRITE), 0);
        @(negedge PCLK);
        chk("t3_second_penable", 32'(PENABLE), 1);
        drain("t3");

        // Slave 1 never ready: timeout after 16 ACCESS cycles, read data untouched.
        never_ready = 1'b1;
        rdata_v = 8'h99;
        req(1'b1, 9'h044, 8'h00);
        expect_done(1'b1, 8'h3C, cyc + 19);
        @(negedge PCLK);
        transfer = 1'b0;
        count_penable("t4", 16);
        drain("t4");
        chk("t4_idle_psel1", 32'(PSEL1), 0);
        chk("t4_idle_penable", 32'(PENABLE), 0);
        never_ready = 1'b0;

        // PSLVERR on a read still returns the data.
        slverr_v = 1'b1;
        rdata_v = 8'h77;
        req(1'b1, 9'h021, 8'h00);
        expect_done(1'b1, 8'h77, cyc + 4);
        @(negedge PCLK);
        transfer = 1'b0;
        drain("t5");
        slverr_v = 1'b0;

        // Asynchronous reset in the middle of ACCESS: no done, clean restart.
        never_ready = 1'b1;
        req(1'b0, 9'h1F0, 8'hAB);
        @(negedge PCLK);
        transfer = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("t6_penable_before_reset", 32'(PENABLE), 1);
        #2;
        PRESET = 1'b1;
        #1;
        check_idle("t6_async");
        @(negedge PCLK);
        @(negedge PCLK);
        check_idle("t6_held");
        PRESET = 1'b0;
        never_ready = 1'b0;
        wait_n = 1;
        req(1'b0, 9'h0FF, 8'h12);
        expect_done(1'b0, 8'h00, cyc + 5);
        @(negedge PCLK);
        transfer = 1'b0;
        chk("t6_restart_psel_latency", 32'(PSEL1), 0);
        @(negedge PCLK);
        chk("t6_restart_psel1", 32'(PSEL1), 1);
        chk("t6_restart_paddr", 32'(PADDR), 'hFF);
        chk("t6_restart_pwdata", 32'(PWDATA), 'h12);
        chk("t6_restart_penable", 32'(PENABLE), 0);
        drain("t6");

        // Zero-wait read from slave 2 after the restart.
        wait_n = 0;
        rdata_v = 8'h5E;
        req(1'b1, 9'h180, 8'h00);
        expect_done(1'b0, 8'h5E, cyc + 4);
        @(negedge PCLK);
        transfer = 1'b0;
        drain("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the testbench-side request bundle (transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data) into APB3 SETUP/ACCESS cycles.
- Decodes the address MSB to one of two slaves.
- Collects PRDATA into apb_read_data_out.
- Sits directly downstream of the driver-side request interface and upstream of the two APB slaves.

Parameters:
- AW, `AW (9), request address width; PADDR is AW-1 bits, and bit AW-1 selects the slave.
- DW, `DW (8), data width.
- TIMEOUT, 16, maximum ACCESS-phase wait cycles before forced error termination; must be ≥ 1.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- transfer  in  1  request valid (level); sampled only in IDLE or on ACCESS completion.
- READ_WRITE  in  1  1 = read, 0 = write.
- apb_write_paddr  in  AW  write address.
- apb_read_paddr  in  AW  read address.
- apb_write_data  in  DW  write data.
- apb_read_data_out  out  DW  last completed read data.
- done  out  1  one-cycle pulse: transfer completed.
- err  out  1  one-cycle pulse, coincident with done: PSLVERR or timeout.
- PSEL1  out  1  slave 1 select (addr[AW-1] = 0).
- PSEL2  out  1  slave 2 select (addr[AW-1] = 1).
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PADDR  out  AW-1  APB address, i.e. addr[AW-2:0].
- PWDATA  out  DW  APB write data.
- PRDATA1  in  DW  slave 1 read data.
- PRDATA2  in  DW  slave 2 read data.
- PREADY1  in  1  slave 1 ready.
- PREADY2  in  1  slave 2 ready.
- PSLVERR  in  1  shared slave error, valid with the selected slave's PREADY.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - State goes to IDLE; the wait counter clears.
  - All outputs go to 0, including apb_read_data_out, PADDR and PWDATA.
  - No done pulse is issued for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE, transfer=1 at the edge:
  - Capture the request: addr = READ_WRITE ? apb_read_paddr : apb_write_paddr; wdata; rw.
  - Next state is SETUP.
- SETUP (exactly one cycle):
  - PSELx = 1 per addr[AW-1]; PENABLE = 0.
  - PWRITE = ~rw; PADDR and PWDATA are driven from the captured values.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE = 1; PSEL and all address/control/data outputs are held stable.
  - Only the selected slave's PREADY and PRDATA are used; the other slave's inputs are ignored.
  - Wait counter increments each ACCESS cycle with PREADY = 0.
- Completion (selected PREADY = 1 at the edge):
  - done = 1 next cycle.
  - err = PSLVERR.
  - On a read, apb_read_data_out <= selected PRDATA, including on error.
  - On a write, apb_read_data_out is unchanged.
- Timeout (counter reaches TIMEOUT with PREADY still 0):
  - Complete with done = 1, err = 1.
  - apb_read_data_out is unchanged.
- Exit after completion:
  - transfer = 1 at that edge: capture the new request and go directly to SETUP. PSEL stays asserted only if the same slave is selected, and PENABLE drops for one cycle.
  - Otherwise: go to IDLE with PSEL1 = PSEL2 = PENABLE = 0.
- Request inputs are ignored in SETUP and during ACCESS wait cycles.
- Latency:
  - Zero-wait transfer from IDLE: request sampled at edge 0, PSEL at edge 1, PENABLE at edge 2, done (and read data) visible after edge 3.
  - Back-to-back zero-wait throughput is one transfer per 2 cycles.
- Invariants: PSEL1 and PSEL2 are never both high; PENABLE = 1 implies exactly one PSELx = 1.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum type apb_state_e (IDLE, SETUP, ACCESS);
  - the request struct (addr, wdata, rw);
  - the slave-select bit-index constant.
  - AW/DW remain the project-wide `define macros.
- One sub-module, apb_wait_timer: clear, enable, and a TIMEOUT-reached flag, with counter width $clog2(TIMEOUT+1).

Test Plan:
- Write 0x5A to addr 0x005, zero-wait → PSEL1=1, PSEL2=0; PWRITE=1, PADDR=0x05, PWDATA=0x5A; PENABLE at cycle 2; done at cycle 3; err=0.
- Read addr 0x10C, PREADY2 low for 3 ACCESS cycles, PRDATA2=0xC3 → PSEL2 only, PADDR=0x0C; PENABLE held 4 cycles; apb_read_data_out=0xC3 with done; err=0.
- transfer held high: write to slave 1 then read from slave 2, both zero-wait → second SETUP immediately follows first ACCESS; PSEL1→PSEL2 with no IDLE gap; two done pulses 2 cycles apart.
- PREADY1 never asserted, TIMEOUT=16 → ACCESS lasts 16 cycles, then done=1, err=1, FSM returns to IDLE; apb_read_data_out unchanged.
- PSLVERR=1 with PREADY1 on a read of PRDATA1=0x77 → done=1, err=1, apb_read_data_out=0x77.
- PRESET asserted mid-ACCESS (asynchronously, between edges) → all outputs 0 immediately, no done; a new request after release starts cleanly from SETUP.
